// File: rtl/simple_fixed2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : simple_fixed2_pipe
// Purpose  : Shift / rotate / rotate-and-mask execution unit for halfword and
//            word elements of a quadword. Supports register-count (RR) and
//            sign-extended I7 immediate (RI7) forms, with a configurable result
//            latency, a pipeline flush and an in-flight operation counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W : quadword width, multiple of 32
//   ADDR_W : target register address width
//   STAGES : issue-to-result latency in cycles (1..8)
//   CNT_W  : in_flight width, 2**CNT_W > STAGES
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   in_valid   in   issue strobe, operands sampled on the edge while high
//   opcode     in   11-bit RR/RI7 opcode
//   data_ra    in   operand A (bit 0 = MSB, halfword 0 = most significant)
//   data_rb    in   operand B, per-element count source for RR forms
//   immediate  in   I7 field for RI7 forms
//   addr_rt    in   target register
//   flush      in   kills every op in the pipe, including one issued now
//   out_data   out  result quadword
//   out_rt     out  target register of the result
//   out_wr     out  result valid / register-file write enable
//   in_flight  out  number of valid slots currently in the pipe
// ============================================================================
module simple_fixed2_pipe #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int STAGES = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [10:0]       opcode,
    input  logic [DATA_W-1:0] data_ra,
    input  logic [DATA_W-1:0] data_rb,
    input  logic [6:0]        immediate,
    input  logic [ADDR_W-1:0] addr_rt,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_rt,
    output logic              out_wr,
    output logic [CNT_W-1:0]  in_flight
);

    localparam int C_NHW = DATA_W / 16;
    localparam int C_NW  = DATA_W / 32;

    localparam logic [10:0] C_OP_SHLH   = 11'b00001011111;
    localparam logic [10:0] C_OP_SHL    = 11'b00001011011;
    localparam logic [10:0] C_OP_ROTH   = 11'b00001011100;
    localparam logic [10:0] C_OP_ROT    = 11'b00001011000;
    localparam logic [10:0] C_OP_ROTHM  = 11'b00001011101;
    localparam logic [10:0] C_OP_ROTM   = 11'b00001011001;
    localparam logic [10:0] C_OP_SHLHI  = 11'b00001111111;
    localparam logic [10:0] C_OP_SHLI   = 11'b00001111011;
    localparam logic [10:0] C_OP_ROTHI  = 11'b00001111100;
    localparam logic [10:0] C_OP_ROTI   = 11'b00001111000;
    localparam logic [10:0] C_OP_ROTHMI = 11'b00001111101;
    localparam logic [10:0] C_OP_ROTMI  = 11'b00001111001;

    localparam logic [1:0] C_KIND_SHL  = 2'd0;
    localparam logic [1:0] C_KIND_ROT  = 2'd1;
    localparam logic [1:0] C_KIND_ROTM = 2'd2;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic       w_known;
    logic       w_is_hw;
    logic       w_use_imm;
    logic [1:0] w_kind;

    always_comb begin
        w_known   = 1'b1;
        w_is_hw   = 1'b0;
        w_use_imm = 1'b0;
        w_kind    = C_KIND_SHL;
        case (opcode)
            C_OP_SHLH:   begin w_is_hw = 1'b1; w_kind = C_KIND_SHL;  end
            C_OP_SHL:    begin                 w_kind = C_KIND_SHL;  end
            C_OP_ROTH:   begin w_is_hw = 1'b1; w_kind = C_KIND_ROT;  end
            C_OP_ROT:    begin                 w_kind = C_KIND_ROT;  end
            C_OP_ROTHM:  begin w_is_hw = 1'b1; w_kind = C_KIND_ROTM; end
            C_OP_ROTM:   begin                 w_kind = C_KIND_ROTM; end
            C_OP_SHLHI:  begin w_is_hw = 1'b1; w_use_imm = 1'b1; w_kind = C_KIND_SHL;  end
            C_OP_SHLI:   begin                 w_use_imm = 1'b1; w_kind = C_KIND_SHL;  end
            C_OP_ROTHI:  begin w_is_hw = 1'b1; w_use_imm = 1'b1; w_kind = C_KIND_ROT;  end
            C_OP_ROTI:   begin                 w_use_imm = 1'b1; w_kind = C_KIND_ROT;  end
            C_OP_ROTHMI: begin w_is_hw = 1'b1; w_use_imm = 1'b1; w_kind = C_KIND_ROTM; end
            C_OP_ROTMI:  begin                 w_use_imm = 1'b1; w_kind = C_KIND_ROTM; end
            default:     w_known = 1'b0;
        endcase
    end

    // Sign-extended immediate replaces the rb element for every lane.
    logic [15:0] w_imm_h;
    logic [31:0] w_imm_w;
    assign w_imm_h = {{9{immediate[6]}}, immediate};
    assign w_imm_w = {{25{immediate[6]}}, immediate};

    logic [DATA_W-1:0] w_hw_res;
    logic [DATA_W-1:0] w_w_res;
    logic [DATA_W-1:0] w_result;

    // ------------------------------------------------------------------
    // Halfword lanes. Element 0 sits at the most significant end.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < C_NHW; gi++) begin : g_hw
        localparam int C_HI = DATA_W - 1 - 16 * gi;
        logic [15:0] w_a;
        logic [15:0] w_src;
        logic [4:0]  w_neg;
        logic [15:0] w_shl;
        logic [15:0] w_rot;
        logic [15:0] w_rotm;
        logic [15:0] w_res;
        logic        w_unused;

        assign w_a   = data_ra[C_HI -: 16];
        assign w_src = w_use_imm ? w_imm_h : data_rb[C_HI -: 16];
        // Rotate-and-mask takes the two's complement of the count as a
        // right-shift amount; only the low five bits matter.
        assign w_neg  = 5'd0 - w_src[4:0];
        assign w_shl  = w_src[4] ? 16'h0000 : (w_a << w_src[3:0]);
        // A right shift by 16 yields zero, so count 0 degenerates cleanly.
        assign w_rot  = (w_a << w_src[3:0]) | (w_a >> (5'd16 - {1'b0, w_src[3:0]}));
        assign w_rotm = w_neg[4] ? 16'h0000 : (w_a >> w_neg[3:0]);
        assign w_res  = (w_kind == C_KIND_ROT)  ? w_rot  :
                        (w_kind == C_KIND_ROTM) ? w_rotm : w_shl;
        assign w_hw_res[C_HI -: 16] = w_res;
        // Count bits above the mask have no effect on the result.
        assign w_unused = ^w_src[15:5];
    end

    // ------------------------------------------------------------------
    // Word lanes.
    // ------------------------------------------------------------------
    for (genvar gw = 0; gw < C_NW; gw++) begin : g_w
        localparam int C_HI = DATA_W - 1 - 32 * gw;
        logic [31:0] w_a;
        logic [31:0] w_src;
        logic [5:0]  w_neg;
        logic [31:0] w_shl;
        logic [31:0] w_rot;
        logic [31:0] w_rotm;
        logic [31:0] w_res;
        logic        w_unused;

        assign w_a    = data_ra[C_HI -: 32];
        assign w_src  = w_use_imm ? w_imm_w : data_rb[C_HI -: 32];
        assign w_neg  = 6'd0 - w_src[5:0];
        assign w_shl  = w_src[5] ? 32'h0000_0000 : (w_a << w_src[4:0]);
        assign w_rot  = (w_a << w_src[4:0]) | (w_a >> (6'd32 - {1'b0, w_src[4:0]}));
        assign w_rotm = w_neg[5] ? 32'h0000_0000 : (w_a >> w_neg[4:0]);
        assign w_res  = (w_kind == C_KIND_ROT)  ? w_rot  :
                        (w_kind == C_KIND_ROTM) ? w_rotm : w_shl;
        assign w_w_res[C_HI -: 32] = w_res;
        assign w_unused = ^w_src[31:6];
    end

    // Unknown opcodes and bubbles carry an all-zero payload down the pipe.
    assign w_result = (in_valid && w_known) ? (w_is_hw ? w_hw_res : w_w_res) : '0;

    // ------------------------------------------------------------------
    // Delay pipe: stage 0 captures the computed result, later stages only
    // delay it. r_vld marks occupied slots (including unknown opcodes),
    // r_wr marks slots that will write the register file.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_data [STAGES];
    logic [ADDR_W-1:0] r_rt   [STAGES];
    logic              r_wr   [STAGES];
    logic              r_vld  [STAGES];
    logic [CNT_W-1:0]  r_in_flight;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
                r_rt[s]   <= '0;
                r_wr[s]   <= 1'b0;
                r_vld[s]  <= 1'b0;
            end
            r_in_flight <= '0;
        end else if (flush) begin
            // Flush also discards whatever is being issued on this edge.
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
                r_rt[s]   <= '0;
                r_wr[s]   <= 1'b0;
                r_vld[s]  <= 1'b0;
            end
            r_in_flight <= '0;
        end else begin
            r_data[0] <= w_result;
            r_rt[0]   <= in_valid ? addr_rt : '0;
            r_wr[0]   <= in_valid & w_known;
            r_vld[0]  <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                r_data[s] <= r_data[s-1];
                r_rt[s]   <= r_rt[s-1];
                r_wr[s]   <= r_wr[s-1];
                r_vld[s]  <= r_vld[s-1];
            end
            // The slot in the last stage leaves the pipe on this edge.
            case ({in_valid, r_vld[STAGES-1]})
                2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign out_data  = r_data[STAGES-1];
    assign out_rt    = r_rt[STAGES-1];
    assign out_wr    = r_wr[STAGES-1];
    assign in_flight = r_in_flight;

endmodule
`default_nettype wire

// File: tb/tb_simple_fixed2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_fixed2_pipe
// Purpose  : Scoreboard bench for simple_fixed2_pipe. The driver pushes the
//            expected result of every accepted op into a queue; a monitor on
//            the falling clock edge pops and compares when the op is due and
//            checks in_flight every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_fixed2_pipe;

    parameter int STAGES = 2;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int CW = 4;

    localparam logic [10:0] OP_SHLH   = 11'b00001011111;
    localparam logic [10:0] OP_SHL    = 11'b00001011011;
    localparam logic [10:0] OP_ROTH   = 11'b00001011100;
    localparam logic [10:0] OP_ROT    = 11'b00001011000;
    localparam logic [10:0] OP_ROTHM  = 11'b00001011101;
    localparam logic [10:0] OP_ROTM   = 11'b00001011001;
    localparam logic [10:0] OP_SHLHI  = 11'b00001111111;
    localparam logic [10:0] OP_SHLI   = 11'b00001111011;
    localparam logic [10:0] OP_ROTHI  = 11'b00001111100;
    localparam logic [10:0] OP_ROTI   = 11'b00001111000;
    localparam logic [10:0] OP_ROTHMI = 11'b00001111101;
    localparam logic [10:0] OP_ROTMI  = 11'b00001111001;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [10:0]   opcode    = '0;
    logic [DW-1:0] data_ra   = '0;
    logic [DW-1:0] data_rb   = '0;
    logic [6:0]    immediate = '0;
    logic [AW-1:0] addr_rt   = '0;
    logic          flush     = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_rt;
    logic          out_wr;
    logic [CW-1:0] in_flight;

    simple_fixed2_pipe #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .STAGES (STAGES),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .data_ra   (data_ra),
        .data_rb   (data_rb),
        .immediate (immediate),
        .addr_rt   (addr_rt),
        .flush     (flush),
        .out_data  (out_data),
        .out_rt    (out_rt),
        .out_wr    (out_wr),
        .in_flight (in_flight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            issue;
        bit            known;
        logic [DW-1:0] data;
        logic [AW-1:0] rt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   idle_chk = 1'b1;
    bit   do_final = 1'b0;

    logic [10:0] ops [12] = '{OP_SHLH, OP_SHL, OP_ROTH, OP_ROT, OP_ROTHM, OP_ROTM,
                              OP_SHLHI, OP_SHLI, OP_ROTHI, OP_ROTI, OP_ROTHMI, OP_ROTMI};

    // Reference model: each element is treated as an unsigned integer, the
    // count is reduced modulo a power of two and applied arithmetically.
    function automatic logic [DW-1:0] model(input logic [10:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [6:0] im,
                                            output bit known);
        int            w;
        int            kind;
        int            sh;
        bit            use_imm;
        longint        x, s, c, r, mask;
        logic [DW-1:0] res;
        known = 1'b1; w = 32; kind = 0; use_imm = 1'b0; res = '0;
        case (op)
            OP_SHLH:   begin w = 16; kind = 0; end
            OP_SHL:    begin w = 32; kind = 0; end
            OP_ROTH:   begin w = 16; kind = 1; end
            OP_ROT:    begin w = 32; kind = 1; end
            OP_ROTHM:  begin w = 16; kind = 2; end
            OP_ROTM:   begin w = 32; kind = 2; end
            OP_SHLHI:  begin w = 16; kind = 0; use_imm = 1'b1; end
            OP_SHLI:   begin w = 32; kind = 0; use_imm = 1'b1; end
            OP_ROTHI:  begin w = 16; kind = 1; use_imm = 1'b1; end
            OP_ROTI:   begin w = 32; kind = 1; use_imm = 1'b1; end
            OP_ROTHMI: begin w = 16; kind = 2; use_imm = 1'b1; end
            OP_ROTMI:  begin w = 32; kind = 2; use_imm = 1'b1; end
            default:   known = 1'b0;
        endcase
        if (!known) return '0;
        mask = (longint'(1) << w) - 1;
        for (int i = 0; i < DW / w; i++) begin
            sh = DW - w * (i + 1);
            x  = longint'(a >> sh) & mask;
            s  = use_imm ? longint'($signed(im)) : (longint'(b >> sh) & mask);
            case (kind)
                0: begin
                    c = s & longint'(2 * w - 1);
                    r = (c >= w) ? 0 : ((x << c) & mask);
                end
                1: begin
                    c = s & longint'(w - 1);
                    r = ((x << c) | (x >> (w - c))) & mask;
                end
                default: begin
                    c = (-s) & longint'(2 * w - 1);
                    r = (c >= w) ? 0 : (x >> c);
                end
            endcase
            res = res | (DW'(r) << sh);
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        int   n;
        exp_t e;
        n = 0;
        foreach (q[k]) if (q[k].issue <= cyc) n++;
        chk("in_flight", DW'(in_flight), DW'(n));
        if (q.size() > 0 && q[0].issue + STAGES - 1 == cyc) begin
            e = q.pop_front();
            chk("out_wr", DW'(out_wr), DW'(e.known));
            chk("out_data", out_data, e.data);
            if (e.known) chk("out_rt", DW'(out_rt), DW'(e.rt));
        end else begin
            chk("out_wr_idle", DW'(out_wr), '0);
        end
        if (idle_chk) begin
            chk("idle_data", out_data, '0);
            chk("idle_rt", DW'(out_rt), '0);
        end
        if (do_final) chk("queue_empty", DW'(q.size()), '0);
    end

    // Driver: one call per clock; inputs settle 1 time unit after the
    // falling edge and are sampled on the next rising edge.
    task automatic step(input bit v, input logic [10:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [6:0] im, input logic [AW-1:0] t,
                        input bit fl, input bit use_exp, input logic [DW-1:0] exp_d);
        exp_t          e;
        bit            k;
        logic [DW-1:0] d;
        @(negedge clk);
        #1;
        in_valid = v; opcode = op; data_ra = a; data_rb = b;
        immediate = im; addr_rt = t; flush = fl;
        if (fl) begin
            q.delete();
        end else if (v) begin
            d = model(op, a, b, im, k);
            if (use_exp) d = exp_d;
            e.issue = cyc + 1;
            e.known = k;
            e.data  = k ? d : '0;
            e.rt    = t;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        q.delete();
        repeat (n) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : drv
        bit            v;
        bit            fl;
        logic [10:0]   op;
        logic [DW-1:0] rbv;
        logic [DW-1:0] rav;

        // Reset held for three edges, then idle with checks on zeros.
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        idle(5);
        idle_chk = 1'b0;

        // shlh: hw0 shifted by 4, remaining lanes count 16 -> zero.
        rav = rnd();
        rav[DW-1 -: 16] = 16'h1234;
        step(1'b1, OP_SHLH, rav, {16'h0004, {7{16'h0010}}}, '0, 7'h2A, 1'b0, 1'b1,
             {16'h2340, 112'h0});
        idle(STAGES + 1);

        // rot / rotm word cases.
        step(1'b1, OP_ROT, {32'h8000_0001, 96'h0}, {32'h1, 96'h0}, '0, 7'h11, 1'b0, 1'b1,
             {32'h0000_0003, 96'h0});
        step(1'b1, OP_ROTM, {32'h8000_0000, 96'h0}, {32'hFFFF_FFFC, 96'h0}, '0, 7'h12, 1'b0, 1'b1,
             {32'h0800_0000, 96'h0});
        rav = rnd();
        step(1'b1, OP_ROTM, rav, '0, '0, 7'h13, 1'b0, 1'b1, rav);
        idle(STAGES + 1);

        // Immediate forms.
        step(1'b1, OP_ROTHMI, {8{16'h8000}}, rnd(), 7'h7F, 7'h21, 1'b0, 1'b1, {8{16'h4000}});
        rav = rnd();
        step(1'b1, OP_SHLI, rav, rnd(), 7'h40, 7'h22, 1'b0, 1'b1, rav);
        rav = {32'h8000_0001, 32'h1234_5678, 32'hF000_000F, 32'h0000_0000};
        step(1'b1, OP_ROTI, rav, rnd(), 7'h21, 7'h23, 1'b0, 1'b1,
             {32'h0000_0003, 32'h2468_ACF0, 32'hE000_001F, 32'h0000_0000});
        idle(STAGES + 1);

        // Back-to-back with flush on the third issue edge.
        step(1'b1, OP_SHL,  rnd(), rnd(), '0, 7'h31, 1'b0, 1'b0, '0);
        step(1'b1, OP_ROTH, rnd(), rnd(), '0, 7'h32, 1'b0, 1'b0, '0);
        step(1'b1, OP_ROT,  rnd(), rnd(), '0, 7'h33, 1'b1, 1'b0, '0);
        step(1'b1, OP_ROTM, rnd(), rnd(), '0, 7'h34, 1'b0, 1'b0, '0);
        idle(STAGES + 1);

        // Asynchronous reset pulse mid-stream.
        step(1'b1, OP_SHLH, rnd(), rnd(), '0, 7'h41, 1'b0, 1'b0, '0);
        step(1'b1, OP_ROTI, rnd(), rnd(), 7'h05, 7'h42, 1'b0, 1'b0, '0);
        step(1'b1, OP_ROTHM, rnd(), rnd(), '0, 7'h43, 1'b0, 1'b0, '0);
        do_reset(2);
        idle(STAGES + 2);

        // Unknown opcode occupies a slot but never writes.
        step(1'b1, 11'h000, rnd(), rnd(), '0, 7'd5, 1'b0, 1'b0, '0);
        idle(STAGES + 1);

        // Randomized traffic with occasional flushes, unknown opcodes and one reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(2);
            v  = ($urandom_range(0, 4) != 0);
            op = ($urandom_range(0, 9) == 0) ? 11'($urandom) : ops[$urandom_range(0, 11)];
            rbv = rnd();
            if ($urandom_range(0, 1) == 1) rbv = rbv & {8{16'h003F}};
            fl = ($urandom_range(0, 24) == 0);
            step(v, op, rnd(), rbv, 7'($urandom), 7'($urandom), fl, 1'b0, '0);
        end
        idle(STAGES + 2);

        do_final = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simple_fixed2_pipe.md
Name: simple_fixed2_pipe

Overview:
Parametrised successor to the SPU simple-fixed-2 (shift/rotate) execution unit. Executes halfword and word shift, rotate and rotate-and-mask operations on a 128-bit quadword. Both register-count and I7-immediate forms are supported. Adds a configurable pipeline depth, an explicit issue-valid, a pipeline flush, and an in-flight counter. Sits between the register-file read stage and the forwarding/writeback network.

Parameters:
DATA_W, 128, quadword width; multiple of 32.
ADDR_W, 7, target register address width.
STAGES, 2, issue-to-result latency in cycles; legal range 1..8.
CNT_W, 4, width of in_flight; must satisfy 2^CNT_W > STAGES.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low; 0 = reset asserted.
in_valid  input  1  issue strobe; operands sampled on rising clk while 1.
opcode  input  11  instruction opcode, RR/RI7 11-bit form.
data_ra  input  DATA_W  operand A; bit 0 = MSB; halfword 0 = [0:15].
data_rb  input  DATA_W  operand B, per-element count source for RR forms.
immediate  input  7  I7 field for RI7 forms.
addr_rt  input  ADDR_W  target register.
flush  input  1  kills all in-flight operations.
out_data  output  DATA_W  result quadword.
out_rt  output  ADDR_W  target register of the result.
out_wr  output  1  result valid / register-write enable.
in_flight  output  CNT_W  number of valid ops currently in the pipe.

Behaviour:
- Reset (reset=0, asynchronous): all pipe registers cleared. out_data=0, out_rt=0, out_wr=0, in_flight=0. Reset mid-operation drops every in-flight op; no output is produced for them after release.
- Latency: an op issued at edge N appears on out_* during the cycle after edge N+STAGES-1, i.e. exactly STAGES edges after issue. Throughput is one op per cycle. There is no stall and no backpressure.
- Opcode decode (count per element; c = count source):
  - shlh 00001011111: c = rb hw bits[11:15]. Result = ra_hw << c, or 0 if c > 15.
  - shl 00001011011: c = rb word bits[26:31]. Result = ra_w << c, or 0 if c > 31.
  - roth 00001011100: rotate left by rb hw bits[12:15].
  - rot 00001011000: rotate left by rb word bits[27:31].
  - rothm 00001011101: c = (0 - rb_hw) bits[11:15]. Logical right shift by c; 0 if c > 15.
  - rotm 00001011001: c = (0 - rb_w) bits[26:31]. Logical right shift by c; 0 if c > 31.
  - Immediate forms use the sign-extended I7 instead of rb, with the same masks, for all elements:
    - shlhi 00001111111
    - shli 00001111011
    - rothi 00001111100
    - roti 00001111000
    - rothmi 00001111101
    - rotmi 00001111001
  - Any other opcode with in_valid=1: accepted into the pipe with wr=0. The slot counts toward in_flight; out_data=0 at exit.
- Pipe contents per stage: data, rt, wr. Computation is done in stage 1. Later stages only delay.
- Idle cycles (in_valid=0) insert bubbles with wr=0. out_data/out_rt hold the bubble's zeros.
- flush=1 at an edge clears wr and valid in every stage, including any op issued on that same edge. in_flight becomes 0 at that edge.
- in_flight counts valid slots, including those with wr=0 from unknown opcodes. On an edge it increments on issue, decrements on exit, and is unchanged when both happen. It never exceeds STAGES.

Test Plan:
- Reset/idle: hold reset=0 for 3 edges, then release with in_valid=0 for 5 cycles -> out_wr=0, out_data=0, in_flight=0 throughout.
- shlh: ra hw0=0x1234, rb hw0=0x0004, other rb hw=0x0010 -> out hw0=0x2340, hw1..7=0x0000. out_wr=1 exactly STAGES edges after issue, out_rt echoed.
- rot/rotm: rot with ra w0=0x80000001, rb w0=1 -> 0x00000003. rotm with ra w0=0x80000000, rb w0=0xFFFFFFFC -> 0x08000000. rotm with rb w0=0 -> c=0, result unchanged.
- Immediate forms: rothmi I7=0x7F, ra hw=0x8000 -> 0x4000 in all hw. shli I7=0x40 (c=0x40 masked to 0) -> ra unchanged. roti I7=0x21 -> rotate by 1.
- Back-to-back with flush: issue 4 ops on consecutive cycles with STAGES=2, assert flush on the 3rd issue edge -> ops 1-2 emerge with out_wr=1 if already past flush, op 3 is killed, op 4 emerges, in_flight sequence checked each cycle. Repeat with asynchronous reset pulse mid-stream -> no later out_wr.
- Unknown opcode 0x000 with addr_rt=5 -> out_wr stays 0, in_flight rises to 1 then returns to 0. Rerun the whole suite at STAGES=1 and STAGES=5.
